// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Grants one byte per frame and recovers the channel with a watchdog if done never arrives.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned TIMEOUT_CYC = 16384
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [8*NUM_REQ-1:0]          req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          tx_start,
   output logic [7:0]                    tx_data,
   input  logic                          tx_busy,
   input  logic                          tx_done,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          active,
   output logic                          timeout_err
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);
   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     last_grant, last_grant_nxt;
   logic [WD_W-1:0]     wdog, wdog_nxt;
   logic [NUM_REQ-1:0]  req_ready_nxt;
   logic                tx_start_nxt;
   logic [7:0]          tx_data_nxt;
   logic [ID_W-1:0]     grant_id_nxt;
   logic                active_nxt;
   logic                timeout_err_nxt;

   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [7:0]          win_byte;

   // Round-robin search: first valid requester after last_grant, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         logic [ID_W-1:0] cand;
         cand = ID_W'((32'(last_grant) + k) % NUM_REQ);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   assign win_byte = req_data[32'(win_id)*8 +: 8];

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= ID_LAST;
         wdog        <= '0;
         req_ready   <= '0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h00;
         grant_id    <= '0;
         active      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_grant  <= last_grant_nxt;
         wdog        <= wdog_nxt;
         req_ready   <= req_ready_nxt;
         tx_start    <= tx_start_nxt;
         tx_data     <= tx_data_nxt;
         grant_id    <= grant_id_nxt;
         active      <= active_nxt;
         timeout_err <= timeout_err_nxt;
      end
   end

   // Next-state and next-output decode.
   always_comb begin
      state_nxt       = state;
      last_grant_nxt  = last_grant;
      wdog_nxt        = wdog;
      req_ready_nxt   = '0;
      tx_start_nxt    = 1'b0;
      tx_data_nxt     = tx_data;
      grant_id_nxt    = grant_id;
      active_nxt      = active;
      timeout_err_nxt = timeout_err;

      unique case (state)
         IDLE: begin
            if (win_found && !tx_busy) begin
               tx_data_nxt            = win_byte;
               grant_id_nxt           = win_id;
               last_grant_nxt         = win_id;
               active_nxt             = 1'b1;
               req_ready_nxt[win_id]  = 1'b1;
               tx_start_nxt           = 1'b1;
               state_nxt              = LAUNCH;
            end
         end

         // tx_done here cannot belong to this byte yet, so it is ignored.
         LAUNCH: begin
            wdog_nxt  = '0;
            state_nxt = WAIT_DONE;
         end

         // A done arriving with watchdog expiry still counts as success.
         WAIT_DONE: begin
            wdog_nxt = wdog + WD_W'(1);
            if (tx_done) begin
               active_nxt = 1'b0;
               state_nxt  = IDLE;
            end else if (wdog == WD_LAST) begin
               timeout_err_nxt = 1'b1;
               active_nxt      = 1'b0;
               state_nxt       = IDLE;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the uart_tx side is driven by hand.
module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        active;
   logic        timeout_err;

   int errors;
   int checks;

   uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(100)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .active      (active),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Bounded wait for the launch pulse.
   task automatic wait_start(input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (tx_start !== 1'b1 && n < 20);
      chk(tag, 32'(tx_start), 32'd1);
   endtask

   // Complete the frame in flight: LAUNCH cycle, busy period, done pulse.
   task automatic finish_frame(input int busy_cyc);
      tick();
      tx_busy = 1'b1;
      repeat (busy_cyc) tick();
      tx_busy = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   initial begin
      logic seen;
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      tx_busy   = 1'b0;
      tx_done   = 1'b0;
      repeat (3) tick();
      chk("rst_ready",  32'(req_ready),   32'h0);
      chk("rst_start",  32'(tx_start),    32'h0);
      chk("rst_data",   32'(tx_data),     32'h0);
      chk("rst_grant",  32'(grant_id),    32'h0);
      chk("rst_active", 32'(active),      32'h0);
      chk("rst_terr",   32'(timeout_err), 32'h0);
      rst = 1'b0;
      tick();

      // Single request, held off first by a busy uart_tx.
      tx_busy       = 1'b1;
      req_valid     = 4'b0001;
      req_data[7:0] = 8'hB3;
      tick();
      tick();
      chk("busy_hold_start", 32'(tx_start), 32'h0);
      tx_busy = 1'b0;
      tick();
      chk("single_start", 32'(tx_start),  32'h1);
      chk("single_ready", 32'(req_ready), 32'h1);
      chk("single_data",  32'(tx_data),   32'hB3);
      chk("single_grant", 32'(grant_id),  32'h0);
      chk("single_active", 32'(active),   32'h1);
      req_valid = '0;
      tick();
      chk("launch_start", 32'(tx_start),  32'h0);
      chk("launch_ready", 32'(req_ready), 32'h0);
      tx_busy = 1'b1;
      repeat (5) tick();
      chk("hold_data", 32'(tx_data), 32'hB3);
      tx_busy = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("single_done_active", 32'(active), 32'h0);

      // Simultaneous requests 1 and 2 after a grant to 0.
      req_valid      = 4'b0110;
      req_data[15:8] = 8'h11;
      req_data[23:16] = 8'h22;
      wait_start("sim1_start");
      chk("sim1_grant", 32'(grant_id),  32'h1);
      chk("sim1_data",  32'(tx_data),   32'h11);
      chk("sim1_ready", 32'(req_ready), 32'h2);
      req_valid = 4'b0100;
      finish_frame(4);
      chk("gap_start", 32'(tx_start), 32'h0);
      tick();
      chk("sim2_start", 32'(tx_start),  32'h1);
      chk("sim2_grant", 32'(grant_id),  32'h2);
      chk("sim2_data",  32'(tx_data),   32'h22);
      chk("sim2_ready", 32'(req_ready), 32'h4);
      req_valid = '0;
      finish_frame(4);

      // Fairness from reset: all four continuously valid.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_valid = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         wait_start($sformatf("fair%0d_start", i));
         chk($sformatf("fair%0d_grant", i), 32'(grant_id), 32'(i % 4));
         chk($sformatf("fair%0d_data", i),  32'(tx_data),  32'(8'hA0 + 8'(i % 4)));
         finish_frame(3);
      end
      req_valid = '0;
      tick();

      // tx_done during LAUNCH must not end the frame.
      req_valid       = 4'b0010;
      req_data[15:8]  = 8'h3C;
      wait_start("lnd_start");
      req_valid = '0;
      tx_done   = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      chk("lnd_active", 32'(active), 32'h1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("lnd_end_active", 32'(active), 32'h0);

      // Withdrawal: req2 appears and vanishes mid-frame.
      req_valid     = 4'b0001;
      req_data[7:0] = 8'h5C;
      wait_start("wd_start");
      chk("wd_grant", 32'(grant_id), 32'h0);
      req_valid = '0;
      tick();
      tx_busy = 1'b1;
      tick();
      req_valid = 4'b0100;
      repeat (2) tick();
      req_valid = '0;
      tick();
      tx_busy = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen = seen | tx_start;
      end
      chk("wd_no_grant", 32'(seen), 32'h0);

      // done coincident with watchdog expiry counts as success.
      req_valid     = 4'b0001;
      req_data[7:0] = 8'hC3;
      wait_start("edge_start");
      req_valid = '0;
      repeat (100) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("edge_active", 32'(active),      32'h0);
      chk("edge_terr",   32'(timeout_err), 32'h0);

      // Watchdog abort, then the pending requester is served.
      req_valid      = 4'b0010;
      req_data[15:8] = 8'hE1;
      wait_start("to_start");
      chk("to_grant", 32'(grant_id), 32'h1);
      req_valid        = 4'b1000;
      req_data[31:24]  = 8'hD4;
      repeat (100) tick();
      chk("to_pre_terr",   32'(timeout_err), 32'h0);
      chk("to_pre_active", 32'(active),      32'h1);
      tick();
      chk("to_terr",   32'(timeout_err), 32'h1);
      chk("to_active", 32'(active),      32'h0);
      tick();
      chk("to_next_start", 32'(tx_start), 32'h1);
      chk("to_next_grant", 32'(grant_id), 32'h3);
      chk("to_next_data",  32'(tx_data),  32'hD4);
      req_valid = '0;
      finish_frame(3);
      chk("to_sticky", 32'(timeout_err), 32'h1);

      // Asynchronous reset during the launch pulse.
      req_valid     = 4'b0001;
      req_data[7:0] = 8'h77;
      wait_start("mr_start");
      #2 rst = 1'b1;
      #1;
      chk("mr_start_drop", 32'(tx_start),    32'h0);
      chk("mr_ready_drop", 32'(req_ready),   32'h0);
      chk("mr_active",     32'(active),      32'h0);
      chk("mr_data",       32'(tx_data),     32'h0);
      chk("mr_terr",       32'(timeout_err), 32'h0);
      tick();
      rst             = 1'b0;
      req_valid       = 4'b1001;
      req_data[31:24] = 8'h5A;
      wait_start("post_rst_start");
      chk("post_rst_grant", 32'(grant_id), 32'h0);
      chk("post_rst_data",  32'(tx_data),  32'h77);
      req_valid = 4'b1000;
      finish_frame(3);
      wait_start("r3_start");
      chk("r3_grant", 32'(grant_id), 32'h3);
      chk("r3_data",  32'(tx_data),  32'h5A);
      req_valid = '0;
      finish_frame(3);
      chk("final_active", 32'(active), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
